// File: rtl/bcd_display_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bcd_display_pkg                                                |
// | Purpose : Shared types, constants and helpers for the BCD display block. |
// |           Holds the FSM state enum, widths, the blank segment pattern,   |
// |           and the saturation / add-3 helpers used by the converter.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package bcd_display_pkg;

   localparam int unsigned COUNT_W     = 14;
   localparam int unsigned DIGITS      = 4;
   localparam int unsigned CONV_CYCLES = 14;
   localparam int unsigned BCD_W       = DIGITS * 4;

   localparam logic [6:0]         SEG_BLANK = 7'h7F;
   localparam logic [COUNT_W-1:0] MAX_COUNT = 14'd9999;
   localparam logic [3:0]         CONV_LAST = 4'(CONV_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   // Clamp the upstream value to the largest 4-digit decimal number.
   function automatic logic [COUNT_W-1:0] saturate(input logic [COUNT_W-1:0] v);
      return (v > MAX_COUNT) ? MAX_COUNT : v;
   endfunction

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
   // so that it carries correctly into the next decade.
   function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (v[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_display_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bcd_display_if                                                 |
// | Purpose : Valid/ready input channel carrying the binary count.           |
// |   in_valid : producer -> block, count is valid                           |
// |   count    : producer -> block, 14-bit unsigned binary value             |
// |   in_ready : block -> producer, block accepts a value this cycle         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface bcd_display_if;
   import bcd_display_pkg::*;

   logic               in_valid;
   logic [COUNT_W-1:0] count;
   logic               in_ready;

   modport master (output in_valid, output count, input in_ready);
   modport slave  (input in_valid, input count, output in_ready);
endinterface
`default_nettype wire

// File: rtl/bcd_display_seg7_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seg7_decode                                                    |
// | Purpose : Combinational BCD digit to active-low 7-segment pattern.       |
// |   bcd   : 4-bit BCD digit                                                |
// |   blank : force all segments off                                         |
// |   seg   : active-low pattern, bit order {g,f,e,d,c,b,a}                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module seg7_decode
   import bcd_display_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/bcd_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bcd_display                                                    |
// | Purpose : Accepts a binary count, converts it to 4 BCD digits with a     |
// |           serial double-dabble, and drives a multiplexed 4-digit         |
// |           7-segment display with leading-zero blanking.                  |
// |   clk   : clock, rising edge                                             |
// |   rst_n : asynchronous active-low reset                                  |
// |   bus   : valid/ready count input (slave side)                           |
// |   seg   : registered active-low segments {g,f,e,d,c,b,a}                 |
// |   an    : registered one-hot active-low digit select, an[0] = LSD        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bcd_display
   import bcd_display_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4
)(
   input  logic                clk,
   input  logic                rst_n,
   bcd_display_if.slave        bus,
   output logic [6:0]          seg,
   output logic [3:0]          an
);

   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

   state_t             state_q,    state_d;
   logic [COUNT_W-1:0] bin_q,      bin_d;
   logic [BCD_W-1:0]   bcd_q,      bcd_d;
   logic [3:0]         bit_cnt_q,  bit_cnt_d;
   logic [BCD_W-1:0]   disp_q,     disp_d;
   logic [15:0]        scan_cnt_q, scan_cnt_d;
   logic [1:0]         idx_q,      idx_d;
   logic [6:0]         seg_q,      seg_d;
   logic [3:0]         an_q,       an_d;

   logic [BCD_W-1:0]   adj;
   logic [3:0]         blank_vec;
   logic [3:0]         cur_digit;
   logic               cur_blank;

   assign bus.in_ready = (state_q == IDLE);
   assign seg          = seg_q;
   assign an           = an_q;

   // Conversion FSM. The working registers only ever reach the display in
   // LOAD, so a reset mid-conversion simply discards them.
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      bit_cnt_d = bit_cnt_q;
      disp_d    = disp_q;
      adj       = add3_all(bcd_q);
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               bin_d     = saturate(bus.count);
               bcd_d     = '0;
               bit_cnt_d = '0;
               state_d   = CONV;
            end
         end
         CONV: begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            bit_cnt_d      = bit_cnt_q + 4'd1;
            if (bit_cnt_q == CONV_LAST) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            disp_d  = bcd_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Free-running scan; independent of the conversion FSM.
   always_comb begin
      scan_cnt_d = scan_cnt_q + 16'd1;
      idx_d      = idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         idx_d      = idx_q + 2'd1;
      end
   end

   // A digit is blank when it and every digit above it are zero; digit 0
   // always shows. Outputs are built from the next index and next display
   // value so the registered an/seg pair stays aligned with idx_q.
   always_comb begin
      blank_vec[3] = (disp_d[15:12] == 4'd0);
      blank_vec[2] = blank_vec[3] && (disp_d[11:8] == 4'd0);
      blank_vec[1] = blank_vec[2] && (disp_d[7:4] == 4'd0);
      blank_vec[0] = 1'b0;
      cur_digit    = disp_d[{idx_d, 2'b00} +: 4];
      cur_blank    = blank_vec[idx_d];
      an_d         = ~(4'b0001 << idx_d);
   end

   seg7_decode u_seg7_decode (
      .bcd   (cur_digit),
      .blank (cur_blank),
      .seg   (seg_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         bit_cnt_q  <= '0;
         disp_q     <= '0;
         scan_cnt_q <= '0;
         idx_q      <= '0;
         seg_q      <= 7'h40;
         an_q       <= 4'b1110;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         bit_cnt_q  <= bit_cnt_d;
         disp_q     <= disp_d;
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bcd_display                                                 |
// | Purpose : Scoreboard bench for bcd_display. Stimulus pushes the expected |
// |           four segment patterns per accepted count; a monitor pops one   |
// |           entry each time in_ready returns high and checks the scanned   |
// |           digits and the conversion latency. A second instance with      |
// |           SCAN_DIV=1 exercises the fastest scan rate.                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bcd_display;

   // {d3, d2, d1, d0}, 7 bits each
   typedef logic [27:0] exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg, seg1;
   logic [3:0] an, an1;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   bit   mon_busy = 1'b0;

   bcd_display_if dif ();
   bcd_display_if dif1 ();

   bcd_display #(.SCAN_DIV(4)) u_dut (
      .clk (clk), .rst_n (rst_n), .bus (dif), .seg (seg), .an (an)
   );

   bcd_display #(.SCAN_DIV(1)) u_dut1 (
      .clk (clk), .rst_n (rst_n), .bus (dif1), .seg (seg1), .an (an1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   bit   mon_prev = 1'b1;
   int   mon_low  = 0;
   exp_t mon_e;
   int   mon_idx;
   bit   mon_found;

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_prev = 1'b1;
            mon_low  = 0;
         end else if (dif.in_ready && !mon_prev) begin
            mon_busy = 1'b1;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("latency", mon_low, 32'd15);
            end
            mon_low = 0;
            for (int k = 0; k < 16; k++) begin
               if (k > 0) @(negedge clk);
               mon_found = 1'b0;
               mon_idx   = 0;
               for (int i = 0; i < 4; i++) begin
                  if (an == ~(4'b0001 << i)) begin
                     mon_found = 1'b1;
                     mon_idx   = i;
                  end
               end
               chk("an_onehot", {31'd0, mon_found}, 32'd1);
               chk("seg_digit", {25'd0, seg}, {25'd0, mon_e[7*mon_idx +: 7]});
               if (!dif.in_ready) mon_low++;
               mon_prev = dif.in_ready;
            end
            mon_busy = 1'b0;
         end else begin
            if (!dif.in_ready) mon_low++;
            mon_prev = dif.in_ready;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [13:0] v, input exp_t e, input bit expect_done);
      int n;
      n = 0;
      while (!dif.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", {31'd0, dif.in_ready}, 32'd1);
      if (expect_done) exp_q.push_back(e);
      dif.in_valid = 1'b1;
      dif.count    = v;
      @(posedge clk);
      #1;
      dif.in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", {31'd0, (exp_q.size() == 0 && !mon_busy)}, 32'd1);
      @(negedge clk);
   endtask

   // Called right at reset release: an walks 1110,1101,1011,0111 for 4
   // samples each; only digit 0 is lit and shows 0.
   task automatic idle_scan_check(input string tag);
      logic [3:0] ea;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge clk);
         ea = ~(4'b0001 << (k / 4));
         chk({tag, "_an"},  {28'd0, an},  {28'd0, ea});
         chk({tag, "_seg"}, {25'd0, seg}, (k < 4) ? 32'h40 : 32'h7F);
      end
   endtask

   task automatic reset_out_check(input string tag);
      chk({tag, "_in_ready"}, {31'd0, dif.in_ready}, 32'd1);
      chk({tag, "_an"},       {28'd0, an},           32'hE);
      chk({tag, "_seg"},      {25'd0, seg},          32'h40);
   endtask

   logic [3:0] prev_an1;
   int         nw;

   initial begin : stimulus
      rst_n         = 1'b0;
      dif.in_valid  = 1'b0;
      dif.count     = '0;
      dif1.in_valid = 1'b0;
      dif1.count    = '0;
      repeat (3) @(negedge clk);
      reset_out_check("por");

      rst_n = 1'b1;
      #1;
      idle_scan_check("idle");
      @(negedge clk);

      send(14'd1234,  {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1); wait_done();
      send(14'd12000, {7'h10, 7'h10, 7'h10, 7'h10}, 1'b1); wait_done();
      send(14'd9999,  {7'h10, 7'h10, 7'h10, 7'h10}, 1'b1); wait_done();
      send(14'd1005,  {7'h79, 7'h40, 7'h40, 7'h12}, 1'b1); wait_done();
      send(14'd60,    {7'h7F, 7'h7F, 7'h02, 7'h40}, 1'b1); wait_done();

      // 7 is converted while in_valid stays high with 5; 5 must wait.
      send(14'd7, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b1);
      dif.in_valid = 1'b1;
      dif.count    = 14'd5;
      exp_q.push_back({7'h7F, 7'h7F, 7'h7F, 7'h12});
      nw = 0;
      @(negedge clk);
      while (!dif.in_ready && nw < 100) begin
         @(negedge clk);
         nw++;
      end
      chk("hold_ready", {31'd0, dif.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      dif.in_valid = 1'b0;
      wait_done();

      // Reset in the middle of converting 905.
      send(14'd905, '0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      reset_out_check("mid_conv_rst");
      repeat (2) @(negedge clk);
      reset_out_check("mid_conv_rst_hold");
      rst_n = 1'b1;
      #1;
      idle_scan_check("post_rst");
      @(negedge clk);

      // Fastest scan rate with count 0.
      dif1.in_valid = 1'b1;
      dif1.count    = 14'd0;
      @(posedge clk);
      #1;
      dif1.in_valid = 1'b0;
      nw = 0;
      @(negedge clk);
      while (!dif1.in_ready && nw < 40) begin
         @(negedge clk);
         nw++;
      end
      chk("div1_ready", {31'd0, dif1.in_ready}, 32'd1);
      prev_an1 = an1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("div1_an_rot", {28'd0, an1}, {28'd0, prev_an1[2:0], prev_an1[3]});
         chk("div1_seg", {25'd0, seg1}, (an1 == 4'b1110) ? 32'h40 : 32'h7F);
         prev_an1 = an1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
